sobel_bank_writer: RTL and testbench
====================================

Name: sobel_bank_writer

Overview:
- Write-side companion of the Sobel window mux: takes the incoming raster pixel stream and writes each pixel into one of 12 line-buffer RAM banks (4 row slots x 3 column phases).
- Generates, per window, the 4-bit bank-rotation `order` code plus per-phase read addresses consumed by the read path.
- Sits between the camera/UART pixel source and the bank RAMs. The read-side mux and the Sobel core sit downstream.

Parameters:
- IMG_W, 160, pixels per line (>=3)
- IMG_H, 120, lines per frame (>=3)
- ADDR_W, 6, bank word address width; must satisfy 2^ADDR_W >= ceil(IMG_W/3)
- DATA_W, 8, pixel width

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- pix_valid  in  1  source pixel valid
- pix_ready  out  1  block accepts pixel; transfer happens when pix_valid & pix_ready
- pix_data  in  DATA_W  pixel value
- pix_sof  in  1  qualifies the first pixel of a frame
- wr_en  out  12  one-hot bank write enable; bank = slot*3 + phase
- wr_addr  out  ADDR_W  bank write address
- wr_data  out  DATA_W  bank write data
- win_valid  out  1  window issue strobe
- order  out  4  bank rotation code, 0..11
- rd_addr0, rd_addr1, rd_addr2  out  ADDR_W each  read address for banks of column phase 0/1/2
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Storage mapping: pixel (x,y) goes to slot s=y mod 4, phase k=x mod 3, bank s*3+k, address x/3.
  - Counters are incremental (phase 0..2, word, col 0..IMG_W-1, slot 0..3, row). No dividers.
- FSM states: IDLE, FILL, STREAM, FLUSH, DONE.
  - IDLE: pix_ready=1. Transfers without pix_sof are accepted and dropped. A transfer with pix_sof is written as (0,0), then go to FILL.
  - FILL: rows 0..2 are written. No windows. After the last pixel of row 2, go to STREAM.
  - STREAM: rows 3..IMG_H-1. Each accepted pixel at column x with x <= IMG_W-3 also issues a window with left column c=x.
    - Window rows are y-3..y-1; top slot t=(s+1) mod 4.
    - After the last pixel of row IMG_H-1, go to FLUSH.
  - FLUSH: pix_ready=0. Issues IMG_W-2 windows on consecutive cycles, c=0..IMG_W-3, t=(IMG_H+1) mod 4. No writes. Then go to DONE.
  - DONE: single cycle. frame_done=1, pix_ready=0. Then go to IDLE.
- Window encoding:
  - order = t*3 + (c mod 3).
  - rd_addrK = (column of phase K among c..c+2)/3, i.e. c/3 if K >= c mod 3, else c/3+1.
- Latency: wr_en/wr_addr/wr_data, win_valid/order/rd_addr* are all registered, 1 cycle after the accepting edge. wr_en is all-zero on non-write cycles.
- pix_sof during FILL/STREAM: abort the current frame, restart at (0,0) with that pixel in FILL. No frame_done.
- pix_sof is ignored while pix_ready=0 (no transfer).
- rst: state=IDLE, all counters 0. Outputs 0: wr_en, wr_addr, wr_data, win_valid, order, rd_addr*, frame_done. pix_ready=1 in the cycle after rst deasserts. Reset mid-frame discards the frame.
- pix_valid low: counters hold, no writes, no windows.

Optional Feature:
- Macro SOBEL_WIN_COUNT_EN.
- When defined: extra output win_count (16 bits).
  - Counts win_valid pulses in the current frame.
  - Cleared on rst and on the sof transfer.
  - Holds its final value after frame_done.
- When undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package sobel_pkg holds:
  - NUM_BANKS=12, NUM_SLOTS=4, NUM_PHASES=3
  - state encoding
  - order helper function t*3+p, shared with the read-side mux
- One sub-module, sobel_raster_cnt: phase/word/col/slot/row counter with end-of-line/end-of-frame flags. Instantiated once for writes and reused for the FLUSH column sweep.

Test Plan:
- IMG_W=6, IMG_H=5, 30 contiguous pixels (sof on first), values 0..29:
  - wr_en for pixel 10 (x=4,y=1) = bank 4, addr 1, data 10.
  - No win_valid during the first 18 transfers.
- Same run, windows:
  - Row 3 gives orders 0,1,2,0.
  - Row 4 gives 3,4,5,3.
  - Flush gives 6,7,8,6.
  - 12 windows total, frame_done exactly 1 cycle after the last flush window.
- c=1 window: rd_addr0=1, rd_addr1=0, rd_addr2=0.
- c=2 window: rd_addr0=1, rd_addr1=1, rd_addr2=0.
- pix_valid toggling 1/0 every cycle: same write/window sequence as contiguous, stretched. Outputs zero on idle cycles.
- Second sof at pixel 20:
  - Frame restarts; next write is bank 0, addr 0.
  - No frame_done for the aborted frame.
  - Full frame follows normally.
- rst asserted during STREAM: outputs 0 next cycle, pix_ready=1. Non-sof pixels are dropped until sof.
  - With SOBEL_WIN_COUNT_EN: win_count=0 after reset, 12 after the full 6x5 frame.

Source files
------------

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants, state encoding and bank-order helper for the Sobel line buffer
package sobel_pkg;
   localparam int NUM_BANKS  = 12;
   localparam int NUM_SLOTS  = 4;
   localparam int NUM_PHASES = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_STREAM,
      ST_FLUSH,
      ST_DONE
   } state_t;

   // Same code names a write bank (slot, phase) and a read rotation (top slot, c mod 3).
   function automatic logic [3:0] order_code(input logic [1:0] i_t, input logic [1:0] i_p);
      return ({2'b00, i_t} * 4'd3) + {2'b00, i_p};
   endfunction
endpackage

// File: rtl/sobel_raster_cnt.sv
// rtl/sobel_raster_cnt.sv - incremental raster position counter (phase/word/col/slot/row)
import sobel_pkg::*;

module sobel_raster_cnt #(
   parameter int IMG_W  = 160,
   parameter int IMG_H  = 120,
   parameter int ADDR_W = 6
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   i_restart,
   input  logic                                   i_adv,
   output logic [1:0]                             o_phase,
   output logic [ADDR_W-1:0]                      o_word,
   output logic [((IMG_W > 1) ? $clog2(IMG_W) : 1)-1:0] o_col,
   output logic [1:0]                             o_slot,
   output logic [((IMG_H > 1) ? $clog2(IMG_H) : 1)-1:0] o_row,
   output logic                                   o_eol,
   output logic                                   o_eof
);
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [1:0]        r_phase;
   logic [ADDR_W-1:0] r_word;
   logic [COL_W-1:0]  r_col;
   logic [1:0]        r_slot;
   logic [ROW_W-1:0]  r_row;
   logic              w_eol;
   logic              w_eof;

   assign w_eol = (r_col == COL_W'(IMG_W - 1));
   assign w_eof = w_eol && (r_row == ROW_W'(IMG_H - 1));

   // Restart lands on (1,0): the sof pixel itself is written at (0,0) in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= '0;
         r_word  <= '0;
         r_col   <= '0;
         r_slot  <= '0;
         r_row   <= '0;
      end else if (i_restart) begin
         r_phase <= 2'd1;
         r_word  <= '0;
         r_col   <= COL_W'(1);
         r_slot  <= '0;
         r_row   <= '0;
      end else if (i_adv) begin
         if (w_eol) begin
            r_col   <= '0;
            r_phase <= '0;
            r_word  <= '0;
            if (w_eof) begin
               r_row  <= '0;
               r_slot <= '0;
            end else begin
               r_row  <= r_row + ROW_W'(1);
               r_slot <= r_slot + 2'd1;
            end
         end else begin
            r_col <= r_col + COL_W'(1);
            if (r_phase == 2'(NUM_PHASES - 1)) begin
               r_phase <= '0;
               r_word  <= r_word + ADDR_W'(1);
            end else begin
               r_phase <= r_phase + 2'd1;
            end
         end
      end
   end

   assign o_phase = r_phase;
   assign o_word  = r_word;
   assign o_col   = r_col;
   assign o_slot  = r_slot;
   assign o_row   = r_row;
   assign o_eol   = w_eol;
   assign o_eof   = w_eof;
endmodule

// File: rtl/sobel_bank_writer.sv
// rtl/sobel_bank_writer.sv - raster pixel writer into 12 line-buffer banks plus window order/address issue
// Optional win_count output under SOBEL_WIN_COUNT_EN.
import sobel_pkg::*;

module sobel_bank_writer #(
   parameter int IMG_W  = 160,
   parameter int IMG_H  = 120,
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [DATA_W-1:0]     pix_data,
   input  logic                  pix_sof,
   output logic [NUM_BANKS-1:0]  wr_en,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [DATA_W-1:0]     wr_data,
   output logic                  win_valid,
   output logic [3:0]            order,
   output logic [ADDR_W-1:0]     rd_addr0,
   output logic [ADDR_W-1:0]     rd_addr1,
   output logic [ADDR_W-1:0]     rd_addr2,
   output logic                  frame_done
`ifdef SOBEL_WIN_COUNT_EN
   ,output logic [15:0]          win_count
`endif
);
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [1:0] FLUSH_TOP = 2'((IMG_H + 1) % NUM_SLOTS);

   state_t               r_state;
   logic                 r_pix_ready;
   logic [NUM_BANKS-1:0] r_wr_en;
   logic [ADDR_W-1:0]    r_wr_addr;
   logic [DATA_W-1:0]    r_wr_data;
   logic                 r_win_valid;
   logic [3:0]           r_order;
   logic [ADDR_W-1:0]    r_rd_addr0;
   logic [ADDR_W-1:0]    r_rd_addr1;
   logic [ADDR_W-1:0]    r_rd_addr2;
   logic                 r_frame_done;
`ifdef SOBEL_WIN_COUNT_EN
   logic [15:0]          r_win_count;
`endif

   logic                 w_xfer;
   logic                 w_sof;
   logic                 w_in_frame;
   logic                 w_adv;
   logic                 w_win_issue;
   logic [1:0]           w_win_top;
   logic [1:0]           w_phase;
   logic [ADDR_W-1:0]    w_word;
   logic [COL_W-1:0]     w_col;
   logic [1:0]           w_slot;
   logic [ROW_W-1:0]     w_row;
   logic                 w_eol;
   logic                 w_eof;

   assign w_xfer     = pix_valid & r_pix_ready;
   assign w_sof      = w_xfer & pix_sof;
   assign w_in_frame = (r_state == ST_FILL) || (r_state == ST_STREAM);
   assign w_adv      = (w_xfer & ~pix_sof & w_in_frame) || (r_state == ST_FLUSH);

   // FLUSH reuses the write counter, which has wrapped to (0,0), as its column sweep.
   assign w_win_issue = (r_state == ST_FLUSH) ||
                        ((r_state == ST_STREAM) && w_xfer && !pix_sof &&
                         (w_col <= COL_W'(IMG_W - 3)));
   assign w_win_top   = (r_state == ST_FLUSH) ? FLUSH_TOP : (w_slot + 2'd1);

   sobel_raster_cnt #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_restart (w_sof),
      .i_adv     (w_adv),
      .o_phase   (w_phase),
      .o_word    (w_word),
      .o_col     (w_col),
      .o_slot    (w_slot),
      .o_row     (w_row),
      .o_eol     (w_eol),
      .o_eof     (w_eof)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_pix_ready  <= 1'b1;
         r_wr_en      <= '0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_win_valid  <= 1'b0;
         r_order      <= '0;
         r_rd_addr0   <= '0;
         r_rd_addr1   <= '0;
         r_rd_addr2   <= '0;
         r_frame_done <= 1'b0;
`ifdef SOBEL_WIN_COUNT_EN
         r_win_count  <= '0;
`endif
      end else begin
         r_wr_en      <= '0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_win_valid  <= 1'b0;
         r_order      <= '0;
         r_rd_addr0   <= '0;
         r_rd_addr1   <= '0;
         r_rd_addr2   <= '0;
         r_frame_done <= 1'b0;

         // Phase k holds column c+((k-c) mod 3); phases left of c mod 3 sit one word further.
         if (w_win_issue) begin
            r_win_valid <= 1'b1;
            r_order     <= order_code(w_win_top, w_phase);
            r_rd_addr0  <= (w_phase > 2'd0) ? w_word + ADDR_W'(1) : w_word;
            r_rd_addr1  <= (w_phase > 2'd1) ? w_word + ADDR_W'(1) : w_word;
            r_rd_addr2  <= w_word;
`ifdef SOBEL_WIN_COUNT_EN
            r_win_count <= r_win_count + 16'd1;
`endif
         end

         case (r_state)
            ST_IDLE, ST_FILL, ST_STREAM: begin
               if (w_sof) begin
                  r_wr_en     <= NUM_BANKS'(1);
                  r_wr_data   <= pix_data;
                  r_state     <= ST_FILL;
`ifdef SOBEL_WIN_COUNT_EN
                  r_win_count <= '0;
`endif
               end else if (w_xfer && (r_state != ST_IDLE)) begin
                  r_wr_en   <= NUM_BANKS'(1) << order_code(w_slot, w_phase);
                  r_wr_addr <= w_word;
                  r_wr_data <= pix_data;
                  if (w_eof) begin
                     r_state     <= ST_FLUSH;
                     r_pix_ready <= 1'b0;
                  end else if ((r_state == ST_FILL) && w_eol && (w_row == ROW_W'(2))) begin
                     r_state <= ST_STREAM;
                  end
               end
            end
            ST_FLUSH: begin
               if (w_col == COL_W'(IMG_W - 3)) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_frame_done <= 1'b1;
               r_state      <= ST_IDLE;
               r_pix_ready  <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_pix_ready <= 1'b1;
            end
         endcase
      end
   end

   assign pix_ready  = r_pix_ready;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign win_valid  = r_win_valid;
   assign order      = r_order;
   assign rd_addr0   = r_rd_addr0;
   assign rd_addr1   = r_rd_addr1;
   assign rd_addr2   = r_rd_addr2;
   assign frame_done = r_frame_done;
`ifdef SOBEL_WIN_COUNT_EN
   assign win_count  = r_win_count;
`endif
endmodule

// File: tb/tb_sobel_bank_writer.sv
// tb/tb_sobel_bank_writer.sv - self-checking bench for sobel_bank_writer on a 6x5 image
module tb_sobel_bank_writer;
   localparam int W  = 6;
   localparam int H  = 5;
   localparam int AW = 6;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pix_valid = 1'b0;
   logic          pix_sof = 1'b0;
   logic [DW-1:0] pix_data = '0;
   logic          pix_ready;
   logic [11:0]   wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          win_valid;
   logic [3:0]    order;
   logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2;
   logic          frame_done;
`ifdef SOBEL_WIN_COUNT_EN
   logic [15:0]   win_count;
`endif

   always #5 clk = ~clk;

   sobel_bank_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_data   (pix_data),
      .pix_sof    (pix_sof),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .win_valid  (win_valid),
      .order      (order),
      .rd_addr0   (rd_addr0),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .frame_done (frame_done)
`ifdef SOBEL_WIN_COUNT_EN
      ,.win_count (win_count)
`endif
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Frame model: pixel index n -> (x,y) by plain division; mode 0 idle, 1 frame, 2 flush, 3 done.
   int m_mode = 0, m_n = 0, m_fc = 0, m_wc = 0;
   bit m_ready = 1'b1, m_init = 1'b0;
   int e_wr_en, e_addr, e_data, e_wv, e_ord, e_rd0, e_rd1, e_rd2, e_fd;

   task automatic m_win(input int c, input int t);
      e_wv  = 1;
      e_ord = t * 3 + c % 3;
      e_rd0 = (c + (0 - c % 3 + 3) % 3) / 3;
      e_rd1 = (c + (1 - c % 3 + 3) % 3) / 3;
      e_rd2 = (c + (2 - c % 3 + 3) % 3) / 3;
      m_wc++;
   endtask

   always @(posedge clk) begin
      int x, y;
      bit xfer;
      e_wr_en = 0; e_addr = 0; e_data = 0; e_wv = 0; e_ord = 0;
      e_rd0 = 0; e_rd1 = 0; e_rd2 = 0; e_fd = 0;
      if (rst) begin
         m_mode = 0; m_ready = 1'b1; m_wc = 0; m_init = 1'b1;
      end else begin
         xfer = pix_valid && m_ready;
         case (m_mode)
            2: begin
               m_win(m_fc, (H + 1) % 4);
               m_fc++;
               if (m_fc == W - 2) m_mode = 3;
            end
            3: begin
               e_fd = 1; m_mode = 0; m_ready = 1'b1;
            end
            default: if (xfer) begin
               if (pix_sof) begin
                  m_n = 0; m_wc = 0; m_mode = 1;
               end
               if (m_mode == 1) begin
                  x = m_n % W;
                  y = m_n / W;
                  e_wr_en = 1 << ((y % 4) * 3 + x % 3);
                  e_addr  = x / 3;
                  e_data  = int'(pix_data);
                  if (y >= 3 && x <= W - 3) m_win(x, (y % 4 + 1) % 4);
                  m_n++;
                  if (m_n == W * H) begin
                     m_mode = 2; m_fc = 0; m_ready = 1'b0;
                  end
               end
            end
         endcase
      end
   end

   longint q_wr[$], q_ord[$], q_rd[$], q_wd[$], q_fd[$];
   int     last_win = -100;

   always @(negedge clk) begin
      logic [50:0] ev, av;
      if (m_init) begin
         ev = {m_ready, e_wr_en[11:0], e_addr[AW-1:0], e_data[DW-1:0], e_wv[0], e_ord[3:0],
               e_rd0[AW-1:0], e_rd1[AW-1:0], e_rd2[AW-1:0], e_fd[0]};
         av = {pix_ready, wr_en, wr_addr, wr_data, win_valid, order,
               rd_addr0, rd_addr1, rd_addr2, frame_done};
         n_cmp++;
         if (av !== ev) begin
            n_fail++;
            $display("FAIL cycle %0d outputs: got %h expected %h", cyc, av, ev);
         end
`ifdef SOBEL_WIN_COUNT_EN
         check("win_count_model", win_count, m_wc);
`endif
         if (wr_en != '0) q_wr.push_back({wr_en, wr_addr, wr_data});
         if (win_valid) begin
            q_ord.push_back(order);
            q_rd.push_back({rd_addr0, rd_addr1, rd_addr2});
            q_wd.push_back(wr_data);
            last_win = cyc;
         end
         if (frame_done) q_fd.push_back(cyc);
      end
      cyc++;
   end

   function automatic longint at(input longint q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic drive(input bit v, input int d, input bit s);
      pix_valid = v; pix_data = DW'(d); pix_sof = s;
      @(posedge clk); #1;
      pix_valid = 1'b0; pix_sof = 1'b0;
   endtask

   task automatic send_frame(input int base, input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, base + i, i == 0);
         if (gap) drive(1'b0, 0, 1'b0);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 1'b0);
   endtask

   task automatic clear_logs();
      q_wr.delete(); q_ord.delete(); q_rd.delete(); q_wd.delete(); q_fd.delete();
   endtask

   task automatic check_orders(input string name);
      int exp_ord[12] = '{0, 1, 2, 0, 3, 4, 5, 3, 6, 7, 8, 6};
      check({name, "_nwin"}, q_ord.size(), 12);
      for (int i = 0; i < 12; i++) check({name, "_order"}, at(q_ord, i), exp_ord[i]);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("ready_after_rst", pix_ready, 1);
      check("wr_en_after_rst", wr_en, 0);

      clear_logs();
      send_frame(0, 30, 1'b0);
      idle(12);
      check("t1_writes", q_wr.size(), 30);
      check("t1_pix10", at(q_wr, 10), {12'h010, 6'd1, 8'd10});
      check("t1_first_win_data", at(q_wd, 0), 18);
      check_orders("t1");
      check("t1_rd_c1", at(q_rd, 1), {6'd1, 6'd0, 6'd0});
      check("t1_rd_c2", at(q_rd, 2), {6'd1, 6'd1, 6'd0});
      check("t1_fd_count", q_fd.size(), 1);
      check("t1_fd_after_last_win", at(q_fd, 0), last_win + 1);
`ifdef SOBEL_WIN_COUNT_EN
      check("t1_win_count", win_count, 12);
`endif

      clear_logs();
      send_frame(0, 30, 1'b1);
      idle(12);
      check("t2_writes", q_wr.size(), 30);
      check("t2_pix10", at(q_wr, 10), {12'h010, 6'd1, 8'd10});
      check_orders("t2");
      check("t2_fd_count", q_fd.size(), 1);

      clear_logs();
      send_frame(0, 20, 1'b0);
      send_frame(100, 30, 1'b0);
      idle(12);
      check("t3_writes", q_wr.size(), 50);
      check("t3_restart_write", at(q_wr, 20), {12'h001, 6'd0, 8'd100});
      check("t3_fd_count", q_fd.size(), 1);
      check("t3_nwin", q_ord.size(), 14);
      check("t3_restart_first_order", at(q_ord, 2), 0);
      check("t3_last_order", at(q_ord, 13), 6);
      check("t3_fd_after_last_win", at(q_fd, 0), last_win + 1);

      send_frame(0, 22, 1'b0);
      rst = 1'b1;
      drive(1'b0, 0, 1'b0);
      rst = 1'b0;
      check("t4_ready_after_rst", pix_ready, 1);
      check("t4_wr_en_after_rst", wr_en, 0);
      check("t4_win_after_rst", win_valid, 0);
`ifdef SOBEL_WIN_COUNT_EN
      check("t4_win_count_rst", win_count, 0);
`endif
      clear_logs();
      drive(1'b1, 200, 1'b0);
      drive(1'b1, 201, 1'b0);
      drive(1'b1, 202, 1'b0);
      idle(2);
      check("t4_dropped", q_wr.size(), 0);
      send_frame(0, 30, 1'b0);
      idle(12);
      check("t4_writes", q_wr.size(), 30);
      check("t4_first_write", at(q_wr, 0), {12'h001, 6'd0, 8'd0});
      check_orders("t4");
      check("t4_fd_count", q_fd.size(), 1);
`ifdef SOBEL_WIN_COUNT_EN
      check("t4_win_count", win_count, 12);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
